// File: rtl/game_status.sv
// rtl/game_status.sv - Two-player drop game status: turn tracking, BCD move count, scores and 7-segment glyphs
module game_status #(
    parameter int MAX_MOVES = 42,
    parameter int SCORE_MAX = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       move_valid,
    input  logic       win_detected,
    input  logic       new_game,
    output logic       player_turn,
    output logic       won,
    output logic [6:0] zero_seg,
    output logic [6:0] one_seg,
    output logic [6:0] two_seg,
    output logic [6:0] three_seg
);

    typedef enum logic [1:0] {PLAYING, WON, DRAW} state_t;

    localparam logic [3:0] MAX_TENS  = 4'(MAX_MOVES / 10);
    localparam logic [3:0] MAX_UNITS = 4'(MAX_MOVES % 10);
    localparam logic [3:0] SCORE_LIM = 4'(SCORE_MAX);
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    state_t     state, state_nx;
    logic [3:0] tens, units, tens_nx, units_nx, inc_tens, inc_units;
    logic [3:0] score1, score2, score1_nx, score2_nx;
    logic       first_mover, first_mover_nx, turn_nx;
    logic [6:0] zero_nx, one_nx, two_nx, three_nx;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = SEG_BLANK;
        endcase
    endfunction

    always_comb begin
        inc_units = (units == 4'd9) ? 4'd0 : units + 4'd1;
        inc_tens  = (units == 4'd9) ? tens + 4'd1 : tens;
    end

    always_comb begin
        state_nx       = state;
        tens_nx        = tens;
        units_nx       = units;
        score1_nx      = score1;
        score2_nx      = score2;
        first_mover_nx = first_mover;
        turn_nx        = player_turn;

        if (new_game) begin
            state_nx       = PLAYING;
            tens_nx        = 4'd0;
            units_nx       = 4'd0;
            first_mover_nx = ~first_mover;
            turn_nx        = ~first_mover;
        end else if (state == PLAYING && move_valid) begin
            tens_nx  = inc_tens;
            units_nx = inc_units;
            if (win_detected) begin
                // player_turn still names the mover, i.e. the winner
                state_nx = WON;
                if (player_turn) begin
                    if (score1 != SCORE_LIM) score1_nx = score1 + 4'd1;
                end else begin
                    if (score2 != SCORE_LIM) score2_nx = score2 + 4'd1;
                end
            end else if (inc_tens == MAX_TENS && inc_units == MAX_UNITS) begin
                state_nx = DRAW;
            end else begin
                turn_nx = ~player_turn;
            end
        end

        zero_nx  = glyph(score1_nx);
        three_nx = glyph(score2_nx);
        if (state_nx == DRAW) begin
            one_nx = SEG_DASH;
            two_nx = SEG_DASH;
        end else begin
            one_nx = glyph(units_nx);
            two_nx = (tens_nx == 4'd0) ? SEG_BLANK : glyph(tens_nx);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= PLAYING;
            tens        <= 4'd0;
            units       <= 4'd0;
            score1      <= 4'd0;
            score2      <= 4'd0;
            first_mover <= 1'b1;
            player_turn <= 1'b1;
            won         <= 1'b0;
            zero_seg    <= 7'b1000000;
            one_seg     <= 7'b1000000;
            two_seg     <= SEG_BLANK;
            three_seg   <= 7'b1000000;
        end else begin
            state       <= state_nx;
            tens        <= tens_nx;
            units       <= units_nx;
            score1      <= score1_nx;
            score2      <= score2_nx;
            first_mover <= first_mover_nx;
            player_turn <= turn_nx;
            won         <= (state_nx == WON);
            zero_seg    <= zero_nx;
            one_seg     <= one_nx;
            two_seg     <= two_nx;
            three_seg   <= three_nx;
        end
    end

endmodule

// File: tb/tb_game_status.sv
// tb/tb_game_status.sv - Scoreboard bench for game_status against an integer-level game model
module tb_game_status;

    localparam int MAXM = 42;
    localparam int SMAX = 9;
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       move_valid = 1'b0, win_detected = 1'b0, new_game = 1'b0;
    logic       player_turn, won;
    logic [6:0] zero_seg, one_seg, two_seg, three_seg;

    game_status #(.MAX_MOVES(MAXM), .SCORE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset), .move_valid(move_valid), .win_detected(win_detected),
        .new_game(new_game), .player_turn(player_turn), .won(won),
        .zero_seg(zero_seg), .one_seg(one_seg), .two_seg(two_seg), .three_seg(three_seg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic       turn;
        logic       won;
        logic [6:0] z, o, t, th;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [6:0] glyph [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Game model: mode 0 = playing, 1 = won, 2 = draw; score[1] is player 1, score[0] player 2
    int   m_mode, m_moves;
    int   m_score [0:1];
    logic m_first, m_turn;

    task automatic model_reset();
        m_mode = 0; m_moves = 0; m_score[0] = 0; m_score[1] = 0;
        m_first = 1'b1; m_turn = 1'b1;
    endtask

    task automatic model_step(input logic mv, input logic win, input logic ng);
        if (ng) begin
            m_mode = 0; m_moves = 0; m_first = !m_first; m_turn = m_first;
        end else if (m_mode == 0 && mv) begin
            m_moves++;
            if (win) begin
                m_mode = 1;
                if (m_score[m_turn] < SMAX) m_score[m_turn]++;
            end else if (m_moves == MAXM) begin
                m_mode = 2;
            end else begin
                m_turn = !m_turn;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.due  = 0;
        e.turn = m_turn;
        e.won  = (m_mode == 1);
        e.z    = glyph[m_score[1]];
        e.th   = glyph[m_score[0]];
        if (m_mode == 2) begin
            e.o = DASH; e.t = DASH;
        end else begin
            e.o = glyph[m_moves % 10];
            e.t = (m_moves / 10 == 0) ? BLANK : glyph[m_moves / 10];
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("player_turn", {6'b0, player_turn}, {6'b0, e.turn});
            chk("won", {6'b0, won}, {6'b0, e.won});
            chk("zero_seg", zero_seg, e.z);
            chk("one_seg", one_seg, e.o);
            chk("two_seg", two_seg, e.t);
            chk("three_seg", three_seg, e.th);
        end
    end

    task automatic drive(input logic mv, input logic win, input logic ng);
        exp_t e;
        @(posedge clk);
        #1;
        move_valid = mv; win_detected = win; new_game = ng;
        model_step(mv, win, ng);
        e = model_out();
        e.due = cyc + 1;
        q.push_back(e);
    endtask

    // Reset asserted between edges; outputs must change without waiting for a clock
    task automatic do_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        move_valid = 1'b0; win_detected = 1'b0; new_game = 1'b0;
        #1;
        q.delete();
        chk("rst player_turn", {6'b0, player_turn}, 7'd1);
        chk("rst won", {6'b0, won}, 7'd0);
        chk("rst zero_seg", zero_seg, 7'b1000000);
        chk("rst one_seg", one_seg, 7'b1000000);
        chk("rst two_seg", two_seg, BLANK);
        chk("rst three_seg", three_seg, 7'b1000000);
        model_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset();

        // three moves, turn alternates, tens blank
        repeat (3) drive(1, 0, 0);
        drive(0, 0, 0);
        // win_detected without a move is ignored
        drive(0, 1, 0);
        // carry into tens at move 10
        repeat (7) drive(1, 0, 0);
        drive(0, 0, 0);

        // P1 wins on the 7th move, later moves ignored
        do_reset();
        repeat (6) drive(1, 0, 0);
        drive(1, 1, 0);
        repeat (3) drive(1, 0, 0);
        drive(1, 1, 0);

        // draw at MAX_MOVES, then new game
        do_reset();
        repeat (MAXM) drive(1, 0, 0);
        drive(1, 0, 0);
        drive(0, 0, 1);
        drive(0, 0, 0);

        // move and new_game together: move discarded
        repeat (4) drive(1, 0, 0);
        drive(1, 1, 1);
        drive(0, 0, 0);

        // win on the final move beats the draw
        do_reset();
        repeat (MAXM - 1) drive(1, 0, 0);
        drive(1, 1, 0);
        drive(0, 0, 0);

        // player 2 wins ten games, score saturates
        do_reset();
        repeat (10) begin
            drive(0, 0, 1);
            if (m_turn) drive(1, 0, 0);
            drive(1, 1, 0);
        end
        drive(0, 0, 0);
        do_reset();

        // random play
        repeat (3000) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            else drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
                       1'($urandom_range(0, 79) == 0));
        end
        drive(0, 0, 0);
        drive(0, 0, 0);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/game_status.md
GAME_STATUS -- requirements
Module: game_status

Interface
REQ-001 SHALL have parameter MAX_MOVES, default 42, meaning the move count at which a game with no win ends as a draw (legal range 1..99).
REQ-002 SHALL have parameter SCORE_MAX, default 9, meaning the saturation value of each per-player win counter (legal range 1..9).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port move_valid, input, 1 bit: one-cycle pulse when a legal piece drop is committed.
REQ-006 SHALL have port win_detected, input, 1 bit: one-cycle pulse, coincident with the move_valid of the winning move.
REQ-007 SHALL have port new_game, input, 1 bit: one-cycle pulse that starts a new round and keeps the scores.
REQ-008 SHALL have port player_turn, output, 1 bit: 1 = player 1 to move, 0 = player 2 to move.
REQ-009 SHALL have port won, output, 1 bit: high while the state is WON.
REQ-010 SHALL have port zero_seg, output, 7 bits: player 1 score glyph.
REQ-011 SHALL have port one_seg, output, 7 bits: move-count units glyph.
REQ-012 SHALL have port two_seg, output, 7 bits: move-count tens glyph.
REQ-013 SHALL have port three_seg, output, 7 bits: player 2 score glyph.

Function
REQ-014 SHALL encode glyphs active-low as {g,f,e,d,c,b,a} with these values:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- dash=0111111, blank=1111111
REQ-015 SHALL register all outputs; each output reflects an input event one clock after the edge that samples it.
REQ-016 SHALL implement three states: PLAYING, WON and DRAW.
REQ-017 SHALL, in PLAYING on move_valid, increment the two-digit BCD move count: units wrap 9->0 with a carry into tens.
REQ-018 SHALL, in PLAYING on move_valid with win_detected low, toggle player_turn; if the new count equals MAX_MOVES, the state SHALL change to DRAW and player_turn SHALL NOT toggle.
REQ-019 SHALL, in PLAYING on move_valid with win_detected high, count the move, leave player_turn unchanged (it still names the winner), increment the winner's score, and change state to WON.
REQ-020 SHALL give a win priority over a draw when both occur on the same move (move MAX_MOVES).
REQ-021 SHALL saturate each score at SCORE_MAX; a further win leaves that score unchanged.
REQ-022 SHALL ignore win_detected when move_valid is low.
REQ-023 SHALL ignore move_valid and win_detected in WON and in DRAW.
REQ-024 SHALL, on new_game in any state, do all of the following:
- change state to PLAYING;
- clear the move count to 00;
- toggle the first-mover register;
- set player_turn to the new value of the first-mover register.
REQ-025 SHALL give new_game priority over move_valid and win_detected in the same cycle; the move is discarded.
REQ-026 SHALL drive two_seg and one_seg as follows:
- PLAYING and WON: the BCD move count, with the tens digit shown blank when it is 0;
- DRAW: both show dash.
REQ-027 SHALL drive zero_seg and three_seg with the score digits in every state.
REQ-028 SHALL hold won high only in WON.

Reset
REQ-029 SHALL, while reset is high, asynchronously set:
- state = PLAYING, move count = 00, both scores = 0;
- first-mover register = 1, player_turn = 1, won = 0;
- zero_seg = three_seg = 1000000, one_seg = 1000000, two_seg = 1111111.
REQ-030 SHALL discard any game in progress when reset asserts mid-game; the first edge after reset deasserts SHALL evaluate inputs normally.

Verification
REQ-031 SHALL cover this scenario: reset, then 3 move_valid pulses -> player_turn 1,0,1,0 in sequence; one_seg=0110000 (3); two_seg blank.
REQ-032 SHALL cover this scenario: 10 moves -> two_seg=1111001 (1) and one_seg=1000000 (0), showing the BCD carry.
REQ-033 SHALL cover this scenario:
- stimulus: 7th move pulsed together with win_detected;
- response: won=1, player_turn=1, zero_seg=1111001 (P1 score 1);
- stimulus: further move_valid pulses;
- response: move count, player_turn and won unchanged.
REQ-034 SHALL cover this scenario: 42 moves with no win -> DRAW, one_seg=two_seg=0111111, won=0; then new_game -> count 00, player_turn=0.
REQ-035 SHALL cover this scenario: move_valid and new_game in the same cycle during PLAYING -> count=00, no toggle from the move, player_turn equals the new first-mover.
REQ-036 SHALL cover this scenario: player 2 wins 10 games -> three_seg stays 0010000 (9); then assert reset between clock edges -> all outputs at reset values immediately.
